dmem_lsu: RTL and testbench

//   Load/store initiator in front of dmem: takes one core memory op (LB/LH/LW/LBU/LHU/SB/SH/SW),

---
 rtl/dmem_lsu_pkg.sv | 21 ++
 rtl/dmem_lsu_align.sv | 59 +++++
 rtl/dmem_lsu.sv | 134 +++++++++++++
 tb/tb_dmem_lsu.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared funct3 codes, byte-lane masks and FSM state encoding for the dmem load/store unit.
package dmem_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] LANE_B = 4'b0001;
    localparam logic [3:0] LANE_H = 4'b0011;
    localparam logic [3:0] LANE_W = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/dmem_lsu_align.sv
// Byte-lane steering: store mask/replication, load extraction with sign/zero extension, illegal/misaligned flag.
// Purely combinational; no state, no flow control.
module dmem_lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_w_en,
    output logic [31:0] o_din,
    output logic [31:0] o_rdata,
    output logic        o_err
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = 8'(i_rdata >> {i_lo, 3'b000});
    assign w_half = 16'(i_rdata >> {i_lo[1], 4'b0000});

    // Unsigned variants exist only for loads, so a store with BU/HU encoding is illegal.
    always_comb begin
        o_w_en  = '0;
        o_din   = '0;
        o_rdata = '0;
        o_err   = 1'b0;
        case (i_funct3)
            F3_B: begin
                o_w_en  = LANE_B << i_lo;
                o_din   = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_byte[7]}}, w_byte};
            end
            F3_H: begin
                o_w_en  = LANE_H << i_lo;
                o_din   = {2{i_wdata[15:0]}};
                o_rdata = {{16{w_half[15]}}, w_half};
                o_err   = i_lo[0];
            end
            F3_W: begin
                o_w_en  = LANE_W;
                o_din   = i_wdata;
                o_rdata = i_rdata;
                o_err   = |i_lo;
            end
            F3_BU: begin
                o_rdata = {24'd0, w_byte};
                o_err   = i_we;
            end
            F3_HU: begin
                o_rdata = {16'd0, w_half};
                o_err   = i_we | i_lo[0];
            end
            default: o_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_lsu.sv
// Single-outstanding load/store initiator for dmem; accept->resp_valid is 1 (error), 2 (store), 2+MEM_RD_LAT (load).
// req_ready only in IDLE; response held until resp_ready, so a stalled core blocks further requests.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int MEM_RD_LAT = 1
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_w_en,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    localparam int CNT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_RD_LAT > 0) ? MEM_RD_LAT - 1 : 0);

    lsu_state_e        r_state, w_next;
    logic              r_we, r_err;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata, r_rdata;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_idle, w_accept, w_last, w_capture;
    logic              w_al_we, w_al_err;
    logic [2:0]        w_al_funct3;
    logic [1:0]        w_al_lo;
    logic [3:0]        w_al_w_en;
    logic [31:0]       w_al_din, w_al_rdata;
    logic [ADDR_W-1:0] w_word_addr;

    // In IDLE the aligner looks at the live request so the error decision is ready at the accept edge.
    assign w_idle      = (r_state == ST_IDLE);
    assign w_accept    = req_valid & w_idle;
    assign w_al_we     = w_idle ? req_we : r_we;
    assign w_al_funct3 = w_idle ? req_funct3 : r_funct3;
    assign w_al_lo     = w_idle ? req_addr[1:0] : r_addr[1:0];
    assign w_word_addr = {r_addr[ADDR_W-1:2], 2'b00};
    assign w_last      = (r_state == ST_WAIT) && (r_cnt == CNT_LAST);
    assign w_capture   = ((r_state == ST_ISSUE) && !r_we && (MEM_RD_LAT == 0)) || w_last;

    dmem_lsu_align u_align (
        .i_we     (w_al_we),
        .i_funct3 (w_al_funct3),
        .i_lo     (w_al_lo),
        .i_wdata  (r_wdata),
        .i_rdata  (mem_dout),
        .o_w_en   (w_al_w_en),
        .o_din    (w_al_din),
        .o_rdata  (w_al_rdata),
        .o_err    (w_al_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next = w_al_err ? ST_RESP : ST_ISSUE;
            ST_ISSUE: w_next = (r_we || MEM_RD_LAT == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT:  if (w_last) w_next = ST_RESP;
            ST_RESP:  if (resp_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = w_idle;
        resp_valid = (r_state == ST_RESP);
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_addr   = '0;
        mem_w_en   = '0;
        mem_din    = '0;
        case (r_state)
            ST_ISSUE: begin
                mem_addr = w_word_addr;
                if (r_we) begin
                    mem_w_en = w_al_w_en;
                    mem_din  = w_al_din;
                end
            end
            ST_WAIT: mem_addr = w_word_addr;
            ST_RESP: begin
                resp_rdata = r_rdata;
                resp_err   = r_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_accept) begin
                r_we     <= req_we;
                r_err    <= w_al_err;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_rdata  <= '0;
            end
            if (w_capture) r_rdata <= w_al_rdata;
            if (r_state == ST_ISSUE)
                r_cnt <= '0;
            else if ((r_state == ST_WAIT) && !w_last)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: behavioural response/lane model checked every cycle plus directed literal vectors.
module tb_dmem_lsu;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [3:0]  mem_w_en;
    logic [31:0] mem_din;
    logic [31:0] mem_dout = 32'h0;

    logic [31:0] mem [0:255];
    logic        poke_en = 1'b0;
    logic [7:0]  poke_idx = 8'h0;
    logic [31:0] poke_val = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_lsu #(.ADDR_W(32), .MEM_RD_LAT(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_w_en   (mem_w_en),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    always #5 clk = ~clk;

    // dmem stand-in with one cycle of read latency and byte-lane writes
    always @(posedge clk) begin
        if (poke_en)
            mem[poke_idx] <= poke_val;
        else
            for (int b = 0; b < 4; b++)
                if (mem_w_en[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_din[8*b +: 8];
        mem_dout <= mem[mem_addr[9:2]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: one op in flight, response due a fixed number of cycles after accept.
    logic        m_busy = 1'b0, m_drain = 1'b0, m_err = 1'b0, m_store = 1'b0, exp_rv;
    int          m_age = 0, m_lat = 0, sz, lo;
    logic [3:0]  m_mask = 4'h0;
    logic [31:0] m_din = 0, m_waddr = 0, m_rdata = 0, v;

    always @(negedge clk) begin
        if (!rst) begin
            m_busy  = 1'b0;
            m_drain = 1'b0;
            chk("rst req_ready", 32'(req_ready), 32'd1);
            chk("rst resp_valid", 32'(resp_valid), 32'd0);
            chk("rst resp_err", 32'(resp_err), 32'd0);
            chk("rst resp_rdata", resp_rdata, 32'd0);
            chk("rst mem_w_en", 32'(mem_w_en), 32'd0);
            chk("rst mem_addr", mem_addr, 32'd0);
            chk("rst mem_din", mem_din, 32'd0);
        end else begin
            if (m_drain) begin
                m_busy  = 1'b0;
                m_drain = 1'b0;
            end else if (m_busy) begin
                m_age++;
            end
            exp_rv = m_busy && (m_age >= m_lat);
            chk("req_ready", 32'(req_ready), 32'(!m_busy));
            chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
            chk("mem_w_en", 32'(mem_w_en), (m_busy && m_store && m_age == 1) ? 32'(m_mask) : 32'd0);
            if (exp_rv) begin
                chk("resp_rdata", resp_rdata, m_rdata);
                chk("resp_err", 32'(resp_err), 32'(m_err));
            end
            if (m_busy && !m_err && m_age >= 1 && m_age < m_lat)
                chk("mem_addr", mem_addr, m_waddr);
            if (m_busy && m_store && m_age == 1)
                chk("mem_din", mem_din, m_din);
            if (!m_busy && req_valid) begin
                case (req_funct3)
                    3'b000:  sz = 1;
                    3'b001:  sz = 2;
                    3'b010:  sz = 4;
                    3'b100:  sz = req_we ? 0 : 1;
                    3'b101:  sz = req_we ? 0 : 2;
                    default: sz = 0;
                endcase
                lo      = int'(req_addr[1:0]);
                m_err   = !((sz != 0) && (lo % sz == 0));
                m_store = !m_err && req_we;
                m_lat   = m_err ? 1 : (req_we ? 2 : 2 + LAT);
                m_waddr = req_addr & 32'hFFFF_FFFC;
                m_mask  = 4'(((1 << sz) - 1) << lo);
                m_din   = (sz == 1) ? req_wdata[7:0] * 32'h0101_0101 :
                          (sz == 2) ? req_wdata[15:0] * 32'h0001_0001 : req_wdata;
                v = mem[req_addr[9:2]] >> (8 * lo);
                if (sz == 1) begin
                    v = v & 32'hFF;
                    if (req_funct3 == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
                end else if (sz == 2) begin
                    v = v & 32'hFFFF;
                    if (req_funct3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
                end
                m_rdata = (m_err || req_we) ? 32'h0 : v;
                m_busy  = 1'b1;
                m_age   = 0;
            end else if (exp_rv && resp_ready) begin
                m_drain = 1'b1;
            end
        end
    end

    task automatic poke(input logic [7:0] idx, input logic [31:0] val);
        @(posedge clk); #1;
        poke_en = 1'b1; poke_idx = idx; poke_val = val;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic run_op(input string nm, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] e_rdata, input logic e_err, input int e_lat,
                          output logic [3:0] s_wen, output logic [31:0] s_din,
                          output logic [31:0] s_addr);
        int n;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0; s_wen = 4'h0; s_din = 32'h0; s_addr = 32'h0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                s_wen = mem_w_en; s_din = mem_din; s_addr = mem_addr;
            end
            if (resp_valid) break;
        end
        chk({nm, " latency"}, 32'(n), 32'(e_lat));
        chk({nm, " rdata"}, resp_rdata, e_rdata);
        chk({nm, " err"}, 32'(resp_err), 32'(e_err));
    endtask

    logic [3:0]  s_wen;
    logic [31:0] s_din, s_addr;
    int          n;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        rst = 1'b1;

        poke(8'd0, 32'h0);
        run_op("SB", 1'b1, 3'b000, 32'h8000_0001, 32'h2022_1118, 32'h0, 1'b0, 2, s_wen, s_din, s_addr);
        chk("SB w_en", 32'(s_wen), 32'h2);
        chk("SB din", s_din, 32'h1818_1818);
        chk("SB addr", s_addr, 32'h8000_0000);
        chk("SB mem word", mem[0], 32'h0000_1800);

        poke(8'd0, 32'h1198_7251);
        run_op("LW", 1'b0, 3'b010, 32'h0010_0000, 32'h0, 32'h1198_7251, 1'b0, 3, s_wen, s_din, s_addr);
        chk("LW addr", s_addr, 32'h0010_0000);

        poke(8'd0, 32'h8000_1234);
        run_op("LB neg", 1'b0, 3'b000, 32'h0010_0003, 32'h0, 32'hFFFF_FF80, 1'b0, 3, s_wen, s_din, s_addr);
        run_op("LH neg", 1'b0, 3'b001, 32'h8000_0002, 32'h0, 32'hFFFF_8000, 1'b0, 3, s_wen, s_din, s_addr);
        run_op("LBU", 1'b0, 3'b100, 32'h0010_0003, 32'h0, 32'h0000_0080, 1'b0, 3, s_wen, s_din, s_addr);
        run_op("LHU", 1'b0, 3'b101, 32'h8000_0002, 32'h0, 32'h0000_8000, 1'b0, 3, s_wen, s_din, s_addr);
        run_op("LB pos", 1'b0, 3'b000, 32'h0010_0000, 32'h0, 32'h0000_0034, 1'b0, 3, s_wen, s_din, s_addr);
        run_op("LH pos", 1'b0, 3'b001, 32'h0010_0000, 32'h0, 32'h0000_1234, 1'b0, 3, s_wen, s_din, s_addr);
        run_op("LW misaligned", 1'b0, 3'b010, 32'h0010_0002, 32'h0, 32'h0, 1'b1, 1, s_wen, s_din, s_addr);
        chk("LW misaligned w_en", 32'(s_wen), 32'h0);

        poke(8'd1, 32'h0);
        run_op("SH", 1'b1, 3'b001, 32'h0000_0006, 32'h1234_BEEF, 32'h0, 1'b0, 2, s_wen, s_din, s_addr);
        chk("SH w_en", 32'(s_wen), 32'hC);
        chk("SH din", s_din, 32'hBEEF_BEEF);
        chk("SH mem word", mem[1], 32'hBEEF_0000);
        run_op("LHU after SH", 1'b0, 3'b101, 32'h0000_0006, 32'h0, 32'h0000_BEEF, 1'b0, 3, s_wen, s_din, s_addr);
        run_op("LH after SH", 1'b0, 3'b001, 32'h0000_0006, 32'h0, 32'hFFFF_BEEF, 1'b0, 3, s_wen, s_din, s_addr);
        run_op("SW", 1'b1, 3'b010, 32'h0000_0008, 32'hCAFE_F00D, 32'h0, 1'b0, 2, s_wen, s_din, s_addr);
        chk("SW w_en", 32'(s_wen), 32'hF);
        run_op("LW after SW", 1'b0, 3'b010, 32'h0000_0008, 32'h0, 32'hCAFE_F00D, 1'b0, 3, s_wen, s_din, s_addr);

        run_op("store f3=100", 1'b1, 3'b100, 32'h0000_0000, 32'h0, 32'h0, 1'b1, 1, s_wen, s_din, s_addr);
        run_op("load f3=011", 1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 1'b1, 1, s_wen, s_din, s_addr);
        run_op("LH odd", 1'b0, 3'b001, 32'h0000_0001, 32'h0, 32'h0, 1'b1, 1, s_wen, s_din, s_addr);
        run_op("SH odd", 1'b1, 3'b001, 32'h0000_0007, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, s_wen, s_din, s_addr);
        chk("SH odd mem untouched", mem[1], 32'hBEEF_0000);

        // Response stalled for three cycles with a second request waiting
        poke(8'd2, 32'h0102_0304);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0008;
        @(posedge clk); #1;
        req_funct3 = 3'b000; req_addr = 32'h0000_0009;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (resp_valid) break;
        end
        chk("stall latency", 32'(n), 32'd3);
        repeat (3) begin
            @(negedge clk);
            chk("stall resp_valid", 32'(resp_valid), 32'd1);
            chk("stall rdata", resp_rdata, 32'h0102_0304);
            chk("stall req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (resp_valid) break;
        end
        chk("queued LB latency", 32'(n), 32'd3);
        chk("queued LB rdata", resp_rdata, 32'h0000_0003);

        // Reset while a load is waiting on memory
        poke(8'd3, 32'hA5A5_A5A5);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_000C;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst in WAIT mem_addr", mem_addr, 32'h0);
        chk("rst in WAIT req_ready", 32'(req_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("no resp after rst", 32'(resp_valid), 32'd0);
        end
        run_op("LW after rst", 1'b0, 3'b010, 32'h0000_000C, 32'h0, 32'hA5A5_A5A5, 1'b0, 3, s_wen, s_din, s_addr);

        // Reset during the single store cycle must suppress the write
        poke(8'd4, 32'h1234_5678);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_0010;
        req_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("rst in ISSUE w_en", 32'(mem_w_en), 32'h0);
        chk("rst in ISSUE din", mem_din, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("SW aborted mem", mem[4], 32'h1234_5678);
        run_op("SW after rst", 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, s_wen, s_din, s_addr);
        chk("SW after rst w_en", 32'(s_wen), 32'hF);
        chk("SW after rst mem", mem[4], 32'hDEAD_BEEF);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1);
    end

endmodule
